// File: rtl/sram_axi_bridge_if.sv
// AXI3 bus bundle between the SRAM bridge (master) and the crossbar (slave).
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's fetch and data SRAM-like ports onto one AXI3 master.
// One outstanding transaction per port; reads demuxed by rid[0].
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    sram_axi_bridge_if.master axi
);

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    ar_state_t   ar_state, ar_next;
    w_state_t    w_state, w_next;
    logic        inst_busy, data_busy;
    logic        aw_done, w_done;
    logic        data_rd_acc, inst_rd_acc, store_acc;
    logic        aw_fin, w_fin;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
    logic        unused_in;

    assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         axi.rresp, axi.rlast, axi.rid[3:1],
                         axi.bid, axi.bresp};

    assign aw_fin = aw_done | axi.awready;
    assign w_fin  = w_done | axi.wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            w_state  <= W_IDLE;
        end else begin
            ar_state <= ar_next;
            w_state  <= w_next;
        end
    end

    always_comb begin
        ar_next     = ar_state;
        w_next      = w_state;
        data_rd_acc = 1'b0;
        inst_rd_acc = 1'b0;
        store_acc   = 1'b0;
        unique case (ar_state)
            AR_IDLE: begin
                // data port beats fetch; a store also blocks a fetch this cycle
                if (data_sram_req && !data_sram_wr && !data_busy
                    && w_state == W_IDLE)
                    data_rd_acc = 1'b1;
                else if (data_sram_req && data_sram_wr && !data_busy
                         && w_state == W_IDLE)
                    store_acc = 1'b1;
                else if (inst_sram_req && !inst_busy)
                    inst_rd_acc = 1'b1;
                if (data_rd_acc || inst_rd_acc)
                    ar_next = AR_SEND;
            end
            AR_SEND: if (axi.arready) ar_next = AR_IDLE;
            default: ar_next = AR_IDLE;
        endcase
        unique case (w_state)
            W_IDLE: if (store_acc) w_next = W_SEND;
            W_SEND: if (aw_fin && w_fin) w_next = W_RESP;
            W_RESP: if (axi.bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc | store_acc;
    assign inst_sram_data_ok = axi.rvalid & ~axi.rid[0] & inst_busy;
    assign data_sram_data_ok = (axi.rvalid & axi.rid[0] & data_busy)
                             | (w_state == W_RESP & axi.bvalid);
    assign inst_sram_rdata   = axi.rdata;
    assign data_sram_rdata   = axi.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_busy <= 1'b0;
            data_busy <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_id     <= 4'd0;
            ar_addr   <= 32'd0;
            ar_size   <= 3'd0;
            aw_addr   <= 32'd0;
            aw_size   <= 3'd0;
            w_strb    <= 4'd0;
            w_data    <= 32'd0;
        end else begin
            if (inst_rd_acc)            inst_busy <= 1'b1;
            else if (inst_sram_data_ok) inst_busy <= 1'b0;
            if (data_rd_acc || store_acc) data_busy <= 1'b1;
            else if (data_sram_data_ok)   data_busy <= 1'b0;
            if (data_rd_acc) begin
                ar_id   <= 4'd1;
                ar_addr <= data_sram_addr;
                ar_size <= {1'b0, data_sram_size};
            end else if (inst_rd_acc) begin
                ar_id   <= 4'd0;
                ar_addr <= inst_sram_addr;
                ar_size <= {1'b0, inst_sram_size};
            end
            if (store_acc) begin
                aw_addr <= data_sram_addr;
                aw_size <= {1'b0, data_sram_size};
                w_strb  <= data_sram_wstrb;
                w_data  <= data_sram_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_SEND) begin
                if (axi.awready) aw_done <= 1'b1;
                if (axi.wready)  w_done  <= 1'b1;
            end
        end
    end

    assign axi.arid    = ar_id;
    assign axi.araddr  = ar_addr;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = ar_size;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (ar_state == AR_SEND);
    assign axi.rready  = 1'b1;
    assign axi.awid    = 4'd1;
    assign axi.awaddr  = aw_addr;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = aw_size;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = (w_state == W_SEND) & ~aw_done;
    assign axi.wid     = 4'd1;
    assign axi.wdata   = w_data;
    assign axi.wstrb   = w_strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (w_state == W_SEND) & ~w_done;
    assign axi.bready  = (w_state == W_RESP);

endmodule
